// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared data-memory size codes, store FSM states and legality helper
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_MERGE,
    ST_WRITE
  } dm_state_t;

  // Byte stores are legal at any lane; halves need even lanes, words lane 0.
  function automatic logic size_legal(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: size_legal = 1'b1;
      SZ_HALF: size_legal = ~lane[0];
      SZ_WORD: size_legal = (lane == 2'b00);
      default: size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// rtl/dm_lane_merge.sv - overlays right-aligned store data onto the old memory word
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0: merged[7:0]   = st_data[7:0];
          2'd1: merged[15:8]  = st_data[7:0];
          2'd2: merged[23:16] = st_data[7:0];
          default: merged[31:24] = st_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = st_data[15:0];
        else         merged[15:0]  = st_data[15:0];
      end
      SZ_WORD: merged = st_data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/dm_store_rmw.sv
// rtl/dm_store_rmw.sv - store path turning sub-word stores into read-modify-write cycles
module dm_store_rmw
  import dm_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        WByteEn_DM,
  output logic              st_done,
  output logic              st_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  dm_state_t         state, state_nxt;
  logic [MEM_AW-1:0] addr_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       merged;
  logic              accept;
  logic              legal;
  logic              unused_addr_hi;

  // Upper address bits wrap onto the memory.
  assign unused_addr_hi = ^st_addr[31:MEM_AW+2];

  assign accept = st_valid & st_ready;
  assign legal  = size_legal(WByteEn_DM, st_addr[1:0]);

  dm_lane_merge u_merge (
    .old_word (mem_rdata),
    .st_data  (data_q),
    .lane     (lane_q),
    .size     (size_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    st_ready  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    st_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        st_ready = 1'b1;
        if (st_valid && legal)
          state_nxt = (WByteEn_DM == SZ_WORD) ? ST_WRITE : ST_RD;
      end
      ST_RD: begin
        mem_re    = 1'b1;
        state_nxt = ST_MERGE;
      end
      ST_MERGE: state_nxt = ST_WRITE;
      ST_WRITE: begin
        mem_we    = 1'b1;
        st_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Illegal requests are latched too, but only raise the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        addr_q <= st_addr[MEM_AW+1:2];
        lane_q <= st_addr[1:0];
        size_q <= WByteEn_DM;
        data_q <= st_data;
        err_q  <= ~legal;
        if (legal && WByteEn_DM == SZ_WORD) wdata_q <= st_data;
      end
      if (state == ST_MERGE) wdata_q <= merged;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign st_err    = err_q;

endmodule
